// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin arbiter sharing a 2-stage registered logic datapath among NUM_REQ requesters
//   clock     rising-edge system clock
//   reset     asynchronous active-low reset
//   req       per-requester request, held with stable operands until granted
//   ain/bin   packed operands, requester i at [i*DATA_W +: DATA_W]
//   op        (LOGIC_UNIT_OP_SEL_EN only) packed 2-bit opcodes: 00 AND, 01 OR, 10 XOR, 11 NAND
//   gnt       one-hot combinational grant
//   rsp_*     result, requester ID and single-cycle valid, two edges after the grant
//   busy      any pipeline stage holds a valid operation
// Optional feature macro: LOGIC_UNIT_OP_SEL_EN
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] ain,
  input  logic [NUM_REQ*DATA_W-1:0] bin,
`ifdef LOGIC_UNIT_OP_SEL_EN
  input  logic [NUM_REQ*2-1:0]      op,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);
  logic [ID_W-1:0] ptr_q, ptr_d, sel, up_sel, wrap_sel;
  logic any, up, xfer;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_d_q, s2_d_d, res;
  logic [ID_W-1:0] s1_id_q, s1_id_d, s2_id_q, s2_id_d;
`ifdef LOGIC_UNIT_OP_SEL_EN
  logic [1:0] s1_op_q, s1_op_d;
`endif
  // Descending scan leaves the lowest set index: up_sel among indices >= ptr, wrap_sel overall.
  always_comb begin
    up_sel = '0;
    wrap_sel = '0;
    any = 1'b0;
    up = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        wrap_sel = ID_W'(i);
        any = 1'b1;
      end
      if (req[i] && ID_W'(i) >= ptr_q) begin
        up_sel = ID_W'(i);
        up = 1'b1;
      end
    end
    sel = up ? up_sel : wrap_sel;
    xfer = any & reset;
    gnt = xfer ? (NUM_REQ'(1) << sel) : '0;
    ptr_d = xfer ? ((sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1) : ptr_q;
  end
  always_comb begin
    s1_v_d = xfer;
    s1_a_d = xfer ? ain[sel*DATA_W +: DATA_W] : s1_a_q;
    s1_b_d = xfer ? bin[sel*DATA_W +: DATA_W] : s1_b_q;
    s1_id_d = xfer ? sel : s1_id_q;
`ifdef LOGIC_UNIT_OP_SEL_EN
    s1_op_d = xfer ? op[sel*2 +: 2] : s1_op_q;
    res = (s1_op_q == 2'b00) ? (s1_a_q & s1_b_q) :
          (s1_op_q == 2'b01) ? (s1_a_q | s1_b_q) :
          (s1_op_q == 2'b10) ? (s1_a_q ^ s1_b_q) : ~(s1_a_q & s1_b_q);
`else
    res = s1_a_q & s1_b_q;
`endif
    s2_v_d = s1_v_q;
    s2_d_d = s1_v_q ? res : s2_d_q;
    s2_id_d = s1_v_q ? s1_id_q : s2_id_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      s1_v_q <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_id_q <= '0;
`ifdef LOGIC_UNIT_OP_SEL_EN
      s1_op_q <= '0;
`endif
      s2_v_q <= 1'b0;
      s2_d_q <= '0;
      s2_id_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      s1_v_q <= s1_v_d;
      s1_a_q <= s1_a_d;
      s1_b_q <= s1_b_d;
      s1_id_q <= s1_id_d;
`ifdef LOGIC_UNIT_OP_SEL_EN
      s1_op_q <= s1_op_d;
`endif
      s2_v_q <= s2_v_d;
      s2_d_q <= s2_d_d;
      s2_id_q <= s2_id_d;
    end
  end
  assign rsp_valid = s2_v_q;
  assign rsp_id = s2_id_q;
  assign rsp_data = s2_d_q;
  assign busy = s1_v_q | s2_v_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: randomized bench checking logic_unit_arbiter against a behavioural model
module tb_logic_unit_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] ain = '0;
  logic [N*W-1:0] bin = '0;
`ifdef LOGIC_UNIT_OP_SEL_EN
  logic [N*2-1:0] op = '0;
`endif
  logic [N-1:0] gnt;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_data;
  logic busy;

  logic_unit_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clock(clock), .reset(reset), .req(req), .ain(ain), .bin(bin),
`ifdef LOGIC_UNIT_OP_SEL_EN
    .op(op),
`endif
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ptr = 0;
  int exp_g = -1;
  bit xv[4096];
  int xid[4096];
  logic [W-1:0] xd[4096];
  int obs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] opres(input int i);
    logic [W-1:0] a = ain[i*W +: W];
    logic [W-1:0] b = bin[i*W +: W];
`ifdef LOGIC_UNIT_OP_SEL_EN
    case (op[i*2 +: 2])
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a ^ b;
      default: return ~(a & b);
    endcase
`else
    return a & b;
`endif
  endfunction

  // One clock: check grant from the model, record the transfer, then check the registered outputs.
  task automatic cycle();
    logic [N-1:0] eg;
    #1;
    exp_g = reset ? pick() : -1;
    eg = '0;
    if (exp_g >= 0) eg[exp_g] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    if (exp_g >= 0) begin
      xv[cyc+1] = 1'b1;
      xid[cyc+1] = exp_g;
      xd[cyc+1] = opres(exp_g);
      ptr = (exp_g + 1) % N;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    chk("rsp_valid", 32'(rsp_valid), 32'(xv[cyc-1]));
    if (xv[cyc-1]) begin
      chk("rsp_id", 32'(rsp_id), 32'(xid[cyc-1]));
      chk("rsp_data", 32'(rsp_data), 32'(xd[cyc-1]));
    end
    if (rsp_valid) obs.push_back(int'(rsp_id));
    chk("busy", 32'(busy), 32'(xv[cyc] || xv[cyc-1]));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    for (int i = 0; i < 4096; i++) xv[i] = 1'b0;
    ptr = 0;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    chk("rst_hold_gnt", 32'(gnt), 0);
    chk("rst_hold_valid", 32'(rsp_valid), 0);
    chk("rst_hold_busy", 32'(busy), 0);
    reset = 1'b1;
  endtask

  initial begin
    req = '1;
    @(negedge clock);
    do_reset();
    obs.delete();
    for (int k = 0; k < 8; k++) begin
      req = '1;
      #1 chk("rr_gnt_lit", 32'(gnt), 32'(1) << (k % 4));
      cycle();
    end
    req = 4'b1001;
    #1 chk("wrap0_lit", 32'(gnt), 32'h1);
    cycle();
    #1 chk("wrap1_lit", 32'(gnt), 32'h8);
    cycle();
    req = '0;
    repeat (3) cycle();
    chk("rr_count", 32'(obs.size()), 10);
    for (int k = 0; k < 8; k++) chk("rr_id_order", 32'(obs[k]), 32'(k % 4));

    ain[2*W +: W] = 8'hF0;
    bin[2*W +: W] = 8'h3C;
    req = 4'b0100;
    #1 chk("single_gnt_lit", 32'(gnt), 32'h4);
    cycle();
    req = '0;
    cycle();
    chk("single_valid_lit", 32'(rsp_valid), 1);
    chk("single_id_lit", 32'(rsp_id), 2);
    chk("single_data_lit", 32'(rsp_data), 32'h30);
    cycle();

    ain[0 +: W] = 8'hFF;
    bin[0 +: W] = 8'h0F;
    req = 4'b0001;
    cycle();
    req = '1;
    do_reset();
    #1 chk("ptr_restart_lit", 32'(gnt), 32'h1);
    cycle();
    req = '0;
    repeat (3) cycle();

`ifdef LOGIC_UNIT_OP_SEL_EN
    for (int c = 1; c < 4; c++) begin
      logic [W-1:0] want;
      want = (c == 1) ? 8'hAF : (c == 2) ? 8'hA5 : 8'hF5;
      ain[0 +: W] = 8'hAA;
      bin[0 +: W] = 8'h0F;
      op[1:0] = 2'(c);
      req = 4'b0001;
      cycle();
      req = '0;
      cycle();
      chk("op_valid_lit", 32'(rsp_valid), 1);
      chk("op_data_lit", 32'(rsp_data), 32'(want));
    end
    cycle();
`endif

    for (int t = 0; t < 1500; t++) begin
      cycle();
      if (t == 700) begin
        do_reset();
        req = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (exp_g == i) req[i] = 1'b0;
        if (!req[i] && $urandom_range(1, 0) == 1) begin
          req[i] = 1'b1;
          ain[i*W +: W] = 8'($urandom);
          bin[i*W +: W] = 8'($urandom);
`ifdef LOGIC_UNIT_OP_SEL_EN
          op[i*2 +: 2] = 2'($urandom);
`endif
        end
      end
    end
    req = '0;
    repeat (3) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one pipelined, registered 2-operand logic datapath (input-register stage, AND, output-register stage) among NUM_REQ requesters.
- Round-robin arbitration, one operation issued per cycle.
- Results return tagged with the requester ID.
- Sits between requesting client blocks and the shared gate datapath; the datapath is instantiated inside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 8, operand/result width in bits
- ID_W, $clog2(NUM_REQ), response ID width (derived, not overridden)

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req  input  NUM_REQ  per-requester request; held high with operands stable until granted
- ain  input  NUM_REQ*DATA_W  packed operand A; requester i at bits [i*DATA_W +: DATA_W]
- bin  input  NUM_REQ*DATA_W  packed operand B, same packing
- gnt  output  NUM_REQ  one-hot grant, combinational from req and pointer
- rsp_valid  output  1  result valid, single-cycle pulse per operation
- rsp_id  output  ID_W  index of requester owning rsp_data
- rsp_data  output  DATA_W  ain_i & bin_i for the granted requester
- busy  output  1  high while any pipeline stage holds a valid operation

Behaviour:
- Reset (reset=0, asynchronous):
  - rr pointer=0.
  - Stage-1 valid, stage-2 valid, rsp_valid=0; rsp_id=0, rsp_data=0, busy=0.
  - gnt forced to 0 while reset=0.
- Arbitration, each cycle:
  - If req != 0, gnt = first set req bit searching from index ptr upward, wrapping NUM_REQ-1 -> 0. Otherwise gnt=0.
  - At most one gnt bit high; gnt[i] only when req[i]=1.
- Handshake:
  - A transfer occurs on a rising edge where gnt[i]=1.
  - The requester may drop req or present new operands the cycle after.
  - A requester kept high is re-eligible next cycle; it is granted again only when its turn comes.
- Pointer update on each transfer: ptr <= (granted index + 1) mod NUM_REQ. No transfer: ptr holds.
- Fairness: a continuously asserted req waits at most NUM_REQ-1 grants.
- Pipeline:
  - Edge E (transfer): stage 1 captures ain_i, bin_i, ID i, valid=1.
  - Edge E+1: stage 2 registers stage1_a & stage1_b, the ID, and valid.
  - rsp_* outputs are the stage-2 registers. rsp_valid is high for exactly one cycle, the cycle following edge E+1.
  - Fixed latency 2 clock edges; throughput 1 op/cycle; back-to-back grants yield back-to-back rsp_valid pulses.
- Idle outputs: when stage-2 valid=0, rsp_data and rsp_id hold their last values. Benches check them only with rsp_valid.
- No response backpressure; consumers must accept every rsp_valid pulse.
- busy = stage1_valid | stage2_valid.
- Reset mid-operation: in-flight operations are discarded with no rsp_valid, and ptr returns to 0.
- Arithmetic: bitwise only, no width growth; rsp_data is DATA_W bits.

Optional Feature:
- Macro: LOGIC_UNIT_OP_SEL_EN
- Defined:
  - Adds input port op, width NUM_REQ*2, packed per requester.
  - Opcode is captured with the operands: 00 AND, 01 OR, 10 XOR, 11 NAND.
  - Stage 2 applies the captured opcode; latency unchanged.
- Undefined: no op port; the datapath is AND only.

Test Plan:
- Reset sequence:
  - Drive reset=0 with req=4'b1111 -> gnt=0, rsp_valid=0, busy=0.
  - Release -> first grant is gnt=4'b0001.
- Single op: NUM_REQ=4, req[2]=1, ain_2=8'hF0, bin_2=8'h3C for one grant -> gnt=4'b0100 that cycle; rsp_valid pulses 2 edges later with rsp_id=2, rsp_data=8'h30.
- Round-robin fairness: req=4'b1111 held 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 consecutive rsp_valid pulses with IDs in the same order.
- Pointer wrap: last grant=3, then req=4'b1001 -> gnt=4'b0001. Next cycle, with req still 4'b1001 -> gnt=4'b1000.
- Reset mid-flight: grant req0 with ain=8'hFF, bin=8'h0F, then assert reset before edge E+1 -> no rsp_valid, busy=0. After release the pointer restarts at 0.
- LOGIC_UNIT_OP_SEL_EN defined: ain=8'hAA, bin=8'h0F with op=01 -> rsp_data=8'hAF; op=10 -> 8'hA5; op=11 -> 8'hF5.
